life_scheduler: RTL

Sequencing controller for the Game-of-Life cell array built from per-cell dot registers. It generates:
- the one-hot row/column select strobes that write the manual-entry switch value into a single cursor cell;
- the global generation-load strobe that makes every cell latch its next-generation value.

It runs generations at a prescaled rate or single-steps them, and moves an edit cursor from debounced, synchronised pushbuttons. It sits between the board I/O and the cell array.

---
 rtl/life_scheduler_pkg.sv | 14 +
 rtl/life_scheduler_edge_detect.sv | 17 +
 rtl/life_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/life_scheduler_pkg.sv
// Shared types and default geometry for the Game-of-Life sequencing controller.
package life_pkg;
  localparam int DEF_ROWS  = 16;
  localparam int DEF_COLS  = 16;
  localparam int DEF_ROW_W = $clog2(DEF_ROWS);
  localparam int DEF_COL_W = $clog2(DEF_COLS);

  typedef enum logic [1:0] {IDLE, RUN, LOAD, WRITE} state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/life_scheduler_edge_detect.sv
// Rising-edge detector for an already synchronised, debounced button.
// prev resets high so a button held through reset gives no pulse.
module edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic in,
  output logic pulse
);
  logic prev;

  always_ff @(posedge Clock) begin
    if (Reset) prev <= 1'b1;
    else       prev <= in;
  end

  assign pulse = in & ~prev;
endmodule

// File: rtl/life_scheduler.sv
// Sequencer for the Game-of-Life cell array: generation load strobes,
// one-hot write selects for the cursor cell, and cursor movement.
//
// state | meaning
// IDLE  | edit/step mode, waiting for button edges
// RUN   | free-running, prescaler counting towards the next generation
// LOAD  | gen_load high for one cycle
// WRITE | row/column selects high for one cycle
module life_scheduler
  import life_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int TICK_DIV = 25000000,
  parameter int GEN_W    = 16
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      run,
  input  logic                      step,
  input  logic                      write,
  input  logic                      up,
  input  logic                      down,
  input  logic                      left,
  input  logic                      right,
  output logic [ROWS-1:0]           RowSelect,
  output logic [COLS-1:0]           ColumnSelect,
  output logic                      gen_load,
  output logic [idx_w(ROWS)-1:0]    cursor_row,
  output logic [idx_w(COLS)-1:0]    cursor_col,
  output logic [GEN_W-1:0]          gen_count
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam int PW = idx_w(TICK_DIV);

  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);
  localparam logic [COLS-1:0] COL_ONE = COLS'(1);

  logic step_p, write_p, up_p, down_p, left_p, right_p;

  edge_detect u_step  (.Clock(Clock), .Reset(Reset), .in(step),  .pulse(step_p));
  edge_detect u_write (.Clock(Clock), .Reset(Reset), .in(write), .pulse(write_p));
  edge_detect u_up    (.Clock(Clock), .Reset(Reset), .in(up),    .pulse(up_p));
  edge_detect u_down  (.Clock(Clock), .Reset(Reset), .in(down),  .pulse(down_p));
  edge_detect u_left  (.Clock(Clock), .Reset(Reset), .in(left),  .pulse(left_p));
  edge_detect u_right (.Clock(Clock), .Reset(Reset), .in(right), .pulse(right_p));

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          presc_tc;

  assign presc_tc = (presc == PRESC_TC);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run)          state_nxt = RUN;
        else if (step_p)  state_nxt = LOAD;
        else if (write_p) state_nxt = WRITE;
      end
      RUN: begin
        if (!run)          state_nxt = IDLE;
        else if (presc_tc) state_nxt = LOAD;
      end
      LOAD:    state_nxt = run ? RUN : IDLE;
      WRITE:   state_nxt = run ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // LOAD occupies one prescaler slot so run-mode loads are exactly TICK_DIV apart.
  always_ff @(posedge Clock) begin
    if (Reset)
      presc <= '0;
    else if (run && (state == RUN || state == LOAD))
      presc <= presc_tc ? '0 : presc + 1'b1;
    else
      presc <= '0;
  end

  assign gen_load = (state == LOAD);

  always_ff @(posedge Clock) begin
    if (Reset)                  gen_count <= '0;
    else if (state_nxt == LOAD) gen_count <= gen_count + 1'b1;
  end

  // Selects are registered from the pre-move cursor so a same-cycle move cannot leak in.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RowSelect    <= '0;
      ColumnSelect <= '0;
    end else if (state_nxt == WRITE) begin
      RowSelect    <= ROW_ONE << cursor_row;
      ColumnSelect <= COL_ONE << cursor_col;
    end else begin
      RowSelect    <= '0;
      ColumnSelect <= '0;
    end
  end

  logic row_dec, row_inc, col_dec, col_inc;

  assign row_dec = ~run & up_p   & ~down_p;
  assign row_inc = ~run & down_p & ~up_p;
  assign col_dec = ~run & left_p & ~right_p;
  assign col_inc = ~run & right_p & ~left_p;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      if (row_dec)      cursor_row <= (cursor_row == '0)     ? ROW_MAX : cursor_row - 1'b1;
      else if (row_inc) cursor_row <= (cursor_row == ROW_MAX) ? '0      : cursor_row + 1'b1;
      if (col_dec)      cursor_col <= (cursor_col == '0)     ? COL_MAX : cursor_col - 1'b1;
      else if (col_inc) cursor_col <= (cursor_col == COL_MAX) ? '0      : cursor_col + 1'b1;
    end
  end
endmodule
